// File: rtl/cam_seq_search.sv
// cam_seq_search: sequential CAM search front end.
// Holds DEPTH entries of n-bit data plus a valid bit and scans them with a
// single shared comparator, one entry per clock. The lowest matching index wins.
// Optional feature macro: CAM_EARLY_EXIT_EN. When it is defined, the scan
// stops on the first hit. When it is undefined, the scan always covers all
// DEPTH entries. The reported result is the same either way.

module cam_seq_search #(
    parameter  int n     = 8,
    parameter  int m     = 4,
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_addr,
    input  logic [n-1:0]  i_wr_data,
    input  logic          i_wr_vld,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [m-1:0]  i_req_key,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic          o_rsp_match,
    output logic [IW-1:0] o_rsp_index,
    output logic [n-1:0]  o_rsp_data
);

`ifdef CAM_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [n-1:0]  r_entry [DEPTH];
    logic [DEPTH-1:0] r_vbit;
    logic [m-1:0]  r_key;
    logic [IW-1:0] r_idx;
    logic          r_hit;
    logic [IW-1:0] r_hit_idx;
    logic [n-1:0]  r_hit_data;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_rsp_match;
    logic [IW-1:0] r_rsp_index;
    logic [n-1:0]  r_rsp_data;

    logic [n-1:0]  w_key_ext;
    logic [n-1:0]  w_cur_data;
    logic          w_cur_hit;
    logic          w_res_match;
    logic [IW-1:0] w_res_idx;
    logic [n-1:0]  w_res_data;
    logic          w_exit;

    // Shared comparator: the key is zero-extended, so entries with nonzero
    // upper bits can never match. Reads see the table before this edge's write.
    assign w_key_ext  = n'(r_key);
    assign w_cur_data = r_entry[r_idx];
    assign w_cur_hit  = r_vbit[r_idx] && (w_cur_data == w_key_ext);

    // The result folds in the current compare so the final scan cycle can
    // load the response registers directly. An earlier hit always takes precedence.
    assign w_res_match = r_hit | w_cur_hit;
    assign w_res_idx   = r_hit ? r_hit_idx  : (w_cur_hit ? r_idx      : '0);
    assign w_res_data  = r_hit ? r_hit_data : (w_cur_hit ? w_cur_data : '0);
    assign w_exit      = (r_idx == LAST_IDX) || (EARLY_EXIT && w_cur_hit);

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_match = r_rsp_match;
    assign o_rsp_index = r_rsp_index;
    assign o_rsp_data  = r_rsp_data;

    // Table writes (accepted in any state) plus the search FSM with registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_vbit      <= '0;
            r_key       <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            r_hit_data  <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_match <= 1'b0;
            r_rsp_index <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (i_wr_en) begin
                r_entry[i_wr_addr] <= i_wr_data;
                r_vbit[i_wr_addr]  <= i_wr_vld;
            end
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (i_req_valid && r_req_ready) begin
                        r_key       <= i_req_key;
                        r_idx       <= '0;
                        r_hit       <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_cur_hit && !r_hit) begin
                        r_hit      <= 1'b1;
                        r_hit_idx  <= r_idx;
                        r_hit_data <= w_cur_data;
                    end
                    if (w_exit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_match <= w_res_match;
                        r_rsp_index <= w_res_idx;
                        r_rsp_data  <= w_res_data;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_match <= 1'b0;
                        r_rsp_index <= '0;
                        r_rsp_data  <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_seq_search.sv
// Bench for cam_seq_search. It uses a scoreboard queue of expected responses
// and a monitor process that checks every presented response.
// The expected rise times follow CAM_EARLY_EXIT_EN in the same way as the DUT.

module tb_cam_seq_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_vld = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_key = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_match;
    logic [2:0] rsp_index;
    logic [7:0] rsp_data;

`ifdef CAM_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic       match;
        logic [2:0] idx;
        logic [7:0] data;
        int         rise;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    int   last_ec = -100;

    cam_seq_search #(.n(8), .m(4), .DEPTH(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_wr_vld   (wr_vld),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_key  (req_key),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_match(rsp_match),
        .o_rsp_index(rsp_index),
        .o_rsp_data (rsp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    // Monitor: checks rise time and contents of every presented response
    initial begin : monitor
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                seen = 1'b0;
            end else if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
                end else begin
                    if (!seen) begin
                        chk("rsp_rise_edge", 32'(cyc), 32'(q[0].rise));
                        seen = 1'b1;
                    end
                    chk("rsp_match", 32'(rsp_match), 32'(q[0].match));
                    chk("rsp_index", 32'(rsp_index), 32'(q[0].idx));
                    chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        last_ec = cyc + 1;
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic write_entry(input logic [2:0] a, input logic [7:0] d, input logic v);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_vld = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Issue one request. Returns at the negedge after the accept edge.
    task automatic search(input logic [3:0] key, input logic em, input logic [2:0] ei,
                          input logic [7:0] ed, input bit expect_rsp, output int e0);
        int guard = 0;
        exp_t e;
        req_valid = 1'b1;
        req_key = key;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(req_ready), 32'(1));
            req_valid = 1'b0;
            e0 = -1;
            return;
        end
        e0 = cyc + 1;
        if (expect_rsp) begin
            e.match = em; e.idx = ei; e.data = ed;
            e.rise = e0 + ((EE && em) ? (int'(ei) + 1) : 8);
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'(0));
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsp_match"}, 32'(rsp_match), 32'(0));
        chk({tag, "_rsp_index"}, 32'(rsp_index), 32'(0));
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int e0;
        int guard;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'(1));

        // Single hit at index 3
        write_entry(3'd3, 8'h05, 1'b1);
        search(4'h5, 1'b1, 3'd3, 8'h05, 1'b1, e0);
        wait_drain();

        // Miss cases: upper bits set, and an invalid entry
        write_entry(3'd3, 8'h05, 1'b0);
        write_entry(3'd1, 8'h15, 1'b1);
        write_entry(3'd4, 8'h09, 1'b0);
        search(4'h5, 1'b0, 3'd0, 8'h00, 1'b1, e0);
        wait_drain();
        search(4'h9, 1'b0, 3'd0, 8'h00, 1'b1, e0);
        wait_drain();

        // Duplicates: the lowest index wins
        write_entry(3'd2, 8'h0A, 1'b1);
        write_entry(3'd6, 8'h0A, 1'b1);
        search(4'hA, 1'b1, 3'd2, 8'h0A, 1'b1, e0);
        wait_drain();

        // Overwrite entry 2 during the index-0 compare; index 6 must win
        search(4'hA, 1'b1, 3'd6, 8'h0A, 1'b1, e0);
        write_entry(3'd2, 8'h00, 1'b1);
        wait_drain();

        // Backpressure: the response holds and no request is accepted
        rsp_ready = 1'b0;
        search(4'hA, 1'b1, 3'd6, 8'h0A, 1'b1, e0);
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_key = 4'hA;
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        search(4'hA, 1'b1, 3'd6, 8'h0A, 1'b1, e0);
        chk("bp_next_accept_edge", 32'(e0), 32'(last_ec + 1));
        wait_drain();

        // Reset in the middle of a scan: no response, and the table is cleared
        search(4'h0, 1'b0, 3'd0, 8'h00, 1'b0, e0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("midscan");
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_midscan", 32'(req_ready), 32'(1));
        search(4'h0, 1'b0, 3'd0, 8'h00, 1'b1, e0);
        wait_drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/cam_seq_search.md
# cam_seq_search

Sequential search front end for the content-addressable match stage. Holds a small table of n-bit entries, accepts search keys over a valid/ready handshake and scans the table one entry per clock. Returns match flag, lowest matching index and matched entry data over a second valid/ready handshake. Sits directly upstream of the downstream consumer of `match`/`data_out`-style results, replacing per-entry combinational comparators with one time-shared comparator.

## Interface
- `n`, 8, entry data width in bits
- `m`, 4, search key width in bits (m ≤ n)
- `DEPTH`, 8, number of table entries; power of two, ≥ 2
- `IW`, derived `$clog2(DEPTH)`, index width (localparam)

- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  IW  entry to write
- `wr_data`  in  n  entry data
- `wr_vld`  in  1  valid bit written with the entry; 0 invalidates the entry
- `req_valid`  in  1  search request present
- `req_ready`  out  1  block can accept a request
- `req_key`  in  m  search key
- `rsp_valid`  out  1  result present
- `rsp_ready`  in  1  consumer accepts result
- `rsp_match`  out  1  1 = some valid entry matched
- `rsp_index`  out  IW  lowest matching index; 0 on miss
- `rsp_data`  out  n  matched entry data; 0 on miss

## Operation
- Table: DEPTH × (n data + 1 valid). Reset clears all data to 0 and all valid bits to 0.
- Write: on `clk` edge with `wr_en`=1, `entry[wr_addr] <= wr_data`, `vbit[wr_addr] <= wr_vld`. Writes are accepted in every state.
- Compare rule: entry i hits when `vbit[i]`=1 and `entry[i] == {{(n-m){1'b0}}, key}`. The key is zero-extended, so entries with nonzero upper bits never match.
- FSM states:
  - IDLE: `req_ready`=1. `req_valid`=1 latches `req_key` and moves to SCAN with idx=0, hit=0.
  - SCAN: compares entry[idx] each cycle using table contents before that edge's write. On hit, records the first hit only (idx and data). Goes to DONE on early-exit condition (see Configuration) or when idx==DEPTH-1; otherwise idx+1.
  - DONE: `rsp_valid`=1. `rsp_*` hold stable until `rsp_valid && rsp_ready`, then goes to IDLE.
- `req_ready`=0 in SCAN and DONE. There are no back-to-back requests. A request is not accepted in the same cycle that DONE completes.
- Writes to entries already scanned do not affect the current search. A write in the same cycle that compares the same entry sees the old value.
- Duplicates: the lowest index wins.
- Reset outputs: `req_ready`=0 while `rst_n`=0 and 1 after the first non-reset cycle. `rsp_valid`=0, `rsp_match`=0, `rsp_index`=0, `rsp_data`=0.
- Reset mid-operation: at the reset edge, any search in SCAN or DONE is discarded. FSM goes to IDLE and the table is cleared. No response is produced.

## Timing
- Request accepted at edge E0 (`req_valid && req_ready`).
- Early exit, hit at index k: `rsp_valid` rises after edge E0+k+1.
- Miss, or early exit disabled: `rsp_valid` rises after edge E0+DEPTH.
- Response consumed at edge Ec. `req_ready`=1 from Ec, so the next request is accepted no earlier than Ec+1.
- Throughput, no backpressure: one search per (scan length + 2) cycles.

## Configuration
- `CAM_EARLY_EXIT_EN` defined: SCAN terminates on the first hit. Latency depends on the hit index.
- Not defined: SCAN always covers all DEPTH entries. Latency is constant at DEPTH cycles and the reported result is still the lowest matching index. Identical results, different `rsp_valid` timing only.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles → `rsp_valid`=0, `rsp_*`=0, `req_ready`=0. First cycle after release → `req_ready`=1.
- Single hit: write entry 3 = 8'h05 valid, search key 4'h5 → `rsp_match`=1, `rsp_index`=3, `rsp_data`=8'h05. `rsp_valid` after E0+4 (early exit) or E0+8 (not).
- Miss and zero-extension: entry 1 = 8'h15 valid, entry 4 = 8'h09 with `wr_vld`=0, search key 4'h5, then key 4'h9 → both return match=0, index=0, data=8'h00 after E0+8.
- Duplicate and mid-scan write: entries 2 and 6 = 8'h0A, search 4'hA → index 2. Repeat while writing entry 2 = 8'h00 at E0+1 (during index 0 compare) → index 6.
- Backpressure: hit result with `rsp_ready`=0 for 5 cycles → `rsp_*` stable, `req_ready`=0 with `req_valid`=1. Release → one handshake, then the next request is accepted one cycle later.
- Reset mid-scan: assert `rst_n`=0 at E0+2 → no response, all entries invalid. A following search for 4'h0 → match=0.
